// File: rtl/rv32i_types.sv
// Shared types for the RV32 M-extension multiply/divide sequencer.
package rv32i_types;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIXUP,
    S_DONE
  } muldiv_state_t;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply, restoring divide.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   quotient,
  output logic [XLEN-1:0]   remainder
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_diff;

  // acc = {high, low}: product accumulates in high, multiplier shifts out of low;
  // for divide, high is the partial remainder and low collects quotient bits.
  assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
  assign w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (load) begin
      r_acc <= {{XLEN{1'b0}}, a};
      r_b   <= b;
    end else if (step) begin
      if (is_div) begin
        if (!w_diff[XLEN])
          r_acc <= {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        else
          r_acc <= {r_acc[2*XLEN-2:0], 1'b0};
      end else begin
        if (r_acc[0])
          r_acc <= {w_sum, r_acc[XLEN-1:1]};
        else
          r_acc <= {1'b0, r_acc[2*XLEN-1:1]};
      end
    end
  end

  assign acc       = r_acc;
  assign quotient  = r_acc[XLEN-1:0];
  assign remainder = r_acc[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_sequencer.sv
// M-extension sequencer: FSM, special-case shortcuts and sign fixup
// around the muldiv_iter datapath.
module muldiv_sequencer
  import rv32i_types::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITER);

  muldiv_state_t  r_state, w_next;
  muldiv_funct3_t r_f3;
  logic [XLEN-1:0] r_rs1, r_rs2, r_result;
  logic            r_neg1, r_neg2;
  logic [CW-1:0]   r_cnt;

  logic w_accept, w_dz, w_ovf, w_sdiv;
  logic w_s1, w_s2, w_last;
  logic [XLEN-1:0]   w_a, w_b, w_q, w_r, w_spec, w_fix;
  logic [2*XLEN-1:0] w_acc, w_prod;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_sdiv   = funct3[2] && !funct3[0];
  assign w_dz     = funct3[2] && (rs2 == '0);
  assign w_ovf    = w_sdiv && (rs1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (rs2 == '1);
  assign w_last   = (r_cnt == CW'(ITER - 1));

  // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
  always_comb begin
    w_spec = '1;
    if (w_dz)
      w_spec = funct3[1] ? rs1 : '1;
    else if (w_ovf)
      w_spec = funct3[1] ? '0 : rs1;
  end

  assign w_s1 = r_rs1[XLEN-1] && (r_f3 == F3_MULH || r_f3 == F3_MULHSU
                || r_f3 == F3_DIV || r_f3 == F3_REM);
  assign w_s2 = r_rs2[XLEN-1] && (r_f3 == F3_MULH
                || r_f3 == F3_DIV || r_f3 == F3_REM);
  assign w_a  = w_s1 ? -r_rs1 : r_rs1;
  assign w_b  = w_s2 ? -r_rs2 : r_rs2;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (r_state == S_PREP),
    .step      (r_state == S_CALC),
    .is_div    (r_f3[2]),
    .a         (w_a),
    .b         (w_b),
    .acc       (w_acc),
    .quotient  (w_q),
    .remainder (w_r)
  );

  assign w_prod = (r_neg1 ^ r_neg2) ? -w_acc : w_acc;

  always_comb begin
    w_fix = '0;
    unique case (r_f3)
      F3_MUL:                       w_fix = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
      F3_DIV:  w_fix = (r_neg1 ^ r_neg2) ? -w_q : w_q;
      F3_DIVU: w_fix = w_q;
      F3_REM:  w_fix = r_neg1 ? -w_r : w_r;
      F3_REMU: w_fix = w_r;
      default: w_fix = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = (w_dz || w_ovf) ? S_DONE : S_PREP;
      S_PREP:  w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_FIXUP;
      S_FIXUP: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_f3     <= F3_MUL;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_f3  <= muldiv_funct3_t'(funct3);
        r_rs1 <= rs1;
        r_rs2 <= rs2;
        if (w_dz || w_ovf) r_result <= w_spec;
      end
      if (r_state == S_PREP) begin
        r_neg1 <= w_s1;
        r_neg2 <= w_s2;
        r_cnt  <= '0;
      end else if (r_state == S_CALC && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_FIXUP && !flush) r_result <= w_fix;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE) && !flush;
  assign stall  = (start && r_state == S_IDLE)
                  || (r_state != S_IDLE && r_state != S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] last_res = '0;

  muldiv_sequencer #(.XLEN(32), .ITER(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat);
    int   sbad;
    exp_t e;
    sbad = 0;
    @(posedge clk); #1;
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    e.res = exp;
    e.cyc = cyc + lat;
    sb.push_back(e);
    last_res = exp;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      if (stall !== (k < lat)) sbad++;
      if (k == 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("stall profile", 32'(sbad), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   c, d0;
    exp_t e;
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    run_op(3'b000, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 35);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 35);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 35);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 35);
    run_op(3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run_op(3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

    // Reset in the middle of a MULH: no done, outputs drop at once.
    @(posedge clk); #1;
    funct3 = 3'b001; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    chk("rst no done", 32'(done_cnt), 32'(d0));
    run_op(3'b000, 32'd3, 32'd4, 32'd12, 35);

    // Flush a DIV at cycle 10, with start raised alongside the flush.
    @(posedge clk); #1;
    funct3 = 3'b100; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1; start = 1'b1;
    @(posedge clk); #1 flush = 1'b0; start = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush result", result, last_res);
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1 flush = 1'b0; start = 1'b0;
    chk("flush+start idle", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush no done", 32'(done_cnt), 32'(d0));
    chk("flush result held", result, last_res);

    // Start held high: back-to-back accept, inputs toggled while busy.
    @(posedge clk); #1;
    funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd3; start = 1'b1;
    c = cyc;
    e.res = 32'd6; e.cyc = c + 35; sb.push_back(e);
    e.res = 32'd6; e.cyc = c + 71; sb.push_back(e);
    for (int k = 1; k <= 37; k++) begin
      @(posedge clk); #1;
      if (k < 30) begin
        funct3 = 3'(k); rs1 = 32'(k * 13); rs2 = ~32'(k);
      end else begin
        funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd3;
      end
      if (k == 37) start = 1'b0;
    end
    while (cyc < c + 74) @(posedge clk);
    #1;
    chk("b2b busy", 32'(busy), 32'd0);

    repeat (5) @(posedge clk);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
